// File: rtl/latch_pkg.sv
// Shared types and timing defaults for the latch write driver.
// Also holds the elaboration-time check of phase timing against the counter width.
package latch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_CNT_W     = 4;

    // Widest counter the check below can evaluate without overflowing an int.
    localparam int MAX_CNT_W = 30;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit cyc_params_ok(input int s, input int p, input int h, input int w);
        if (s < 1 || p < 1 || h < 1) return 1'b0;
        if (w < 1 || w > MAX_CNT_W) return 1'b0;
        return (max3(s, p, h) - 1) < (1 << w);
    endfunction

endpackage

// File: rtl/latch_phase_counter.sv
// Loadable down-counter timing each latch phase; the FSM decides when to load,
// this block only counts and flags zero.
module latch_phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_driver.sv
// Writer side of a transparent-latch bank: accepts one word per valid/ready handshake
// and sequences registered D / enable through setup, pulse and hold phases.
module latch_write_driver
    import latch_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] latch_d,
    output logic             latch_en,
    output logic             busy,
    output logic             done
);

    if (!cyc_params_ok(SETUP_CYC, PULSE_CYC, HOLD_CYC, CNT_W)) begin : g_param_check
        $error("latch_write_driver: *_CYC must be >= 1 and each minus one must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Counter is reloaded on every phase entry and counts down inside a phase.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                cnt_load     = accept;
                cnt_load_val = SETUP_LD;
            end
            SETUP: begin
                cnt_load     = cnt_zero;
                cnt_load_val = PULSE_LD;
                cnt_dec      = !cnt_zero;
            end
            PULSE: begin
                cnt_load     = cnt_zero;
                cnt_load_val = HOLD_LD;
                cnt_dec      = !cnt_zero;
            end
            HOLD: begin
                cnt_dec      = !cnt_zero;
            end
            default: ;
        endcase
    end

    latch_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Enable, busy and done are flops set on the phase transitions so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            latch_d  <= '0;
            latch_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        latch_d <= in_data;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        latch_en <= 1'b1;
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        latch_en <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    latch_en <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_driver.sv
// Bench for latch_write_driver: a cycle vector table on the default instance, then
// scoreboarded streams on default and (3,1,4) timing instances plus a mid-pulse reset.
module tb_latch_write_driver;
    import latch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       ra, va, rdya, ena, busya, donea;
    logic [7:0] da, lda;
    logic       rb, vb, rdyb, enb, busyb, doneb;
    logic [7:0] db, ldb;

    latch_write_driver #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(ra), .in_valid(va), .in_data(da), .in_ready(rdya),
        .latch_d(lda), .latch_en(ena), .busy(busya), .done(donea)
    );

    latch_write_driver #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rb), .in_valid(vb), .in_data(db), .in_ready(rdyb),
        .latch_d(ldb), .latch_en(enb), .busy(busyb), .done(doneb)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         acc;
    } exp_t;
    exp_t q[$];

    // Scoreboard monitor for whichever instance is streaming.
    bit mon_on  = 1'b0;
    int mon_sel = 0;
    int run     = 0;
    int pulses  = 0;

    task automatic mon(input logic dn, input logic en, input logic bz, input logic [7:0] d,
                       input int s, input int p, input int h);
        exp_t e;
        if (en) begin
            if (run == 0 && q.size() > 0) check("en_rise_offset", cyc - q[0].acc, s);
            run++;
        end else if (run > 0) begin
            check("en_width", run, p);
            run = 0;
            pulses++;
        end
        if (bz && q.size() > 0) check("d_stable_busy", d, q[0].data);
        if (dn) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("done_offset", cyc - e.acc, s + p + h);
                check("done_data", d, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mon_sel == 0) mon(donea, ena, busya, lda, 1, 2, 1);
            else              mon(doneb, enb, busyb, ldb, 3, 1, 4);
        end
    end

    // Drives one instance for n cycles; the bench predicts accepts from its own
    // next-free-edge model and pushes the expected completion at drive time.
    task automatic stream(input int sel, input int n, input int nvalid,
                          input logic [7:0] w0, input logic [7:0] w1, input int total);
        int nf;
        int w;
        int edge_no;
        logic acc;
        logic v;
        logic [7:0] d;
        exp_t e;
        nf = cyc + 1;
        w = 0;
        for (int k = 0; k < n; k++) begin
            edge_no = cyc + 1;
            v   = (k < nvalid);
            acc = v && (edge_no >= nf);
            d   = acc ? ((w == 0) ? w0 : w1) : 8'(k * 37 + 11);
            check($sformatf("in_ready_%0d_k%0d", sel, k), (sel == 0) ? rdya : rdyb, edge_no >= nf);
            if (acc) begin
                e.data = d;
                e.acc  = edge_no;
                q.push_back(e);
                w++;
                nf = edge_no + total;
            end
            if (sel == 0) begin va = v; da = d; end
            else          begin vb = v; db = d; end
            @(negedge clk);
        end
        if (sel == 0) va = 1'b0; else vb = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [11:0] exp;   // {latch_d, latch_en, in_ready, busy, done}
    } vec_t;
    vec_t tbl[9];

    initial begin
        ra = 1'b1; va = 1'b0; da = 8'h00;
        rb = 1'b1; vb = 1'b0; db = 8'h00;

        tbl[0] = '{1'b1, 1'b1, 8'hFF, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[1] = '{1'b1, 1'b1, 8'hFF, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{1'b1, 1'b1, 8'hFF, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[3] = '{1'b0, 1'b1, 8'hA5, {8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[4] = '{1'b0, 1'b0, 8'h3C, {8'hA5, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{1'b0, 1'b1, 8'hC3, {8'hA5, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[6] = '{1'b0, 1'b1, 8'h5A, {8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[7] = '{1'b0, 1'b1, 8'hFF, {8'hA5, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[8] = '{1'b0, 1'b0, 8'h00, {8'hA5, 1'b0, 1'b1, 1'b0, 1'b0}};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            ra = tbl[i].rst; va = tbl[i].v; da = tbl[i].d;
            if (i == 3) rb = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d", i), {lda, ena, rdya, busya, donea}, tbl[i].exp);
        end
        va = 1'b0;
        check("b_reset_state", {ldb, enb, rdyb, busyb, doneb}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

        // Back-to-back on default timing: accepts five edges apart.
        mon_sel = 0; run = 0; pulses = 0; mon_on = 1'b1;
        stream(0, 14, 6, 8'h01, 8'h02, 5);
        check("a_pulse_count", pulses, 2);
        check("a_queue_drained", q.size(), 0);

        // Swept timing: enable rises 3 after accept, 1 wide, ready back at accept+9.
        mon_sel = 1; run = 0; pulses = 0;
        stream(1, 22, 11, 8'h3C, 8'hC9, 9);
        check("b_pulse_count", pulses, 2);
        check("b_queue_drained", q.size(), 0);
        mon_on = 1'b0;

        // Reset during PULSE: everything clears on the next edge and done never fires.
        va = 1'b1; da = 8'h77;
        @(negedge clk);
        va = 1'b0; da = 8'h00;
        @(negedge clk);
        check("pre_reset_en", ena, 1'b1);
        ra = 1'b1;
        @(negedge clk);
        ra = 1'b0;
        check("midreset_outputs", {lda, ena, rdya, busya, donea}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("midreset_quiet_k%0d", k), {ena, donea, busya}, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
